tama_status_fsm: RTL and testbench

- Behaviour-state controller that closes the loop with the level-processing block.
- Consumes the hunger (h), fun (d) and energy (e) levels (0..5), the sick-death flag enMue and the registered user buttons.
- Produces the 3-bit status code that the level processor and display consume.
- Advances on a one-cycle game-step strobe. Evaluation is debounced so that a level crossing must persist before status changes.

---
 rtl/tama_pkg.sv | 23 ++
 rtl/tama_hold_cnt.sv | 42 ++++
 rtl/tama_status_fsm.sv | 76 +++++++
 tb/tb_tama_status_fsm.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tama_pkg.sv
// tama_pkg: status codes and level helpers shared by the status FSM, level processor and display.
package tama_pkg;
  localparam logic [2:0] ST_FELIZ      = 3'd0;
  localparam logic [2:0] ST_ABURRIDO   = 3'd1;
  localparam logic [2:0] ST_CANSADO    = 3'd2;
  localparam logic [2:0] ST_DESCANSO   = 3'd3;
  localparam logic [2:0] ST_HAMBRIENTO = 3'd4;
  localparam logic [2:0] ST_ENFERMO    = 3'd5;
  localparam logic [2:0] ST_MUERTO     = 3'd6;
  localparam int MAX_LVL = 5;
  typedef enum logic [2:0] {
    S_FELIZ      = ST_FELIZ,
    S_ABURRIDO   = ST_ABURRIDO,
    S_CANSADO    = ST_CANSADO,
    S_DESCANSO   = ST_DESCANSO,
    S_HAMBRIENTO = ST_HAMBRIENTO,
    S_ENFERMO    = ST_ENFERMO,
    S_MUERTO     = ST_MUERTO
  } status_t;
  function automatic logic [2:0] sat_lvl(input logic [2:0] l);
    return (l > 3'(MAX_LVL)) ? 3'(MAX_LVL) : l;
  endfunction
endpackage

// File: rtl/tama_hold_cnt.sv
// tama_hold_cnt: debounces the candidate status and counts consecutive starving ticks.
module tama_hold_cnt import tama_pkg::*; #(
  parameter int CNT_W        = 6,
  parameter int HOLD_TICKS   = 4,
  parameter int STARVE_TICKS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold_clr,
  input  logic       hold_en,
  input  logic [2:0] cand,
  input  logic [2:0] status,
  input  logic       starve_clr,
  input  logic       starve_en,
  input  logic       h_zero,
  output logic       commit,
  output logic       starved
);
  logic [CNT_W-1:0] hold, hold_d, starve, starve_d;
  logic [2:0] prev;
  always_comb begin
    hold_d = (prev == cand) ? hold + 1'b1 : CNT_W'(1);
    starve_d = !h_zero ? '0 : (&starve) ? starve : starve + 1'b1;
    commit = hold_en && !hold_clr && cand != status && hold_d == CNT_W'(HOLD_TICKS);
    starved = starve_en && !starve_clr && starve_d >= CNT_W'(STARVE_TICKS);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hold <= '0;
      prev <= ST_FELIZ;
    end else if (hold_clr) begin
      hold <= '0;
      prev <= ST_FELIZ;
    end else if (hold_en) begin
      hold <= (cand == status || commit) ? '0 : hold_d;
      prev <= cand;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) starve <= '0;
    else if (starve_clr) starve <= '0;
    else if (starve_en) starve <= starve_d;
endmodule

// File: rtl/tama_status_fsm.sv
// tama_status_fsm: behaviour-state controller driven by need levels, sickness timeout and buttons.
module tama_status_fsm import tama_pkg::*; #(
  parameter int LOW_LVL      = 1,
  parameter int FULL_LVL     = 5,
  parameter int HOLD_TICKS   = 4,
  parameter int STARVE_TICKS = 60,
  parameter int CNT_W        = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] h,
  input  logic [2:0] d,
  input  logic [2:0] e,
  input  logic       enMue,
  input  logic       regrst,
  input  logic       regtest,
  input  logic       regcurar,
  input  logic       regdormir,
  output logic [2:0] status,
  output logic       chg,
  output logic       testmode
);
  status_t state, state_d, cand;
  logic [2:0] hs, ds, es;
  logic lh, ld, le, bad, normal, sleep, commit, starved;
  assign hs = sat_lvl(h);
  assign ds = sat_lvl(d);
  assign es = sat_lvl(e);
  assign status = state;
  always_comb begin
    lh = hs <= 3'(LOW_LVL);
    ld = ds <= 3'(LOW_LVL);
    le = es <= 3'(LOW_LVL);
    cand = (2'(lh) + 2'(ld) + 2'(le) >= 2'd2) ? S_ENFERMO : lh ? S_HAMBRIENTO :
           le ? S_CANSADO : ld ? S_ABURRIDO : S_FELIZ;
    bad = state == status_t'(3'd7);
    normal = state inside {S_FELIZ, S_ABURRIDO, S_CANSADO, S_HAMBRIENTO};
    sleep = tick && state == S_CANSADO && regdormir;
    state_d = state;
    if (regrst) state_d = S_FELIZ;
    else if (regtest) state_d = (state >= S_MUERTO) ? S_FELIZ : status_t'(state + 3'd1);
    else if (bad) state_d = S_FELIZ;
    else if (tick && state != S_MUERTO) begin
      if (state == S_ENFERMO) state_d = enMue ? S_MUERTO : regcurar ? S_FELIZ : starved ? S_MUERTO : state;
      else if (starved) state_d = S_MUERTO;
      else if (state == S_DESCANSO) state_d = (es >= 3'(FULL_LVL) || regdormir) ? cand : state;
      else if (sleep) state_d = S_DESCANSO;
      else if (commit) state_d = cand;
    end
  end
  // Any non-debounced transition or button action restarts the debounce from scratch.
  tama_hold_cnt #(.CNT_W(CNT_W), .HOLD_TICKS(HOLD_TICKS), .STARVE_TICKS(STARVE_TICKS)) u_cnt (
    .clk(clk),
    .rst(rst),
    .hold_clr(regrst || regtest || bad || sleep || (tick && !normal)),
    .hold_en(tick && normal && !regrst && !regtest),
    .cand(cand),
    .status(state),
    .starve_clr(regrst || regtest),
    .starve_en(tick && state != S_MUERTO && !bad),
    .h_zero(hs == 3'd0),
    .commit(commit),
    .starved(starved)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_FELIZ;
      chg <= 1'b0;
      testmode <= 1'b0;
    end else begin
      state <= state_d;
      chg <= state_d != state;
      testmode <= regrst ? 1'b0 : regtest ? 1'b1 : testmode;
    end
endmodule

// File: tb/tb_tama_status_fsm.sv
// tb_tama_status_fsm: directed plan steps plus random traffic against a rule-level reference model.
module tb_tama_status_fsm;
  logic clk = 0, rst = 0, tick = 0, enMue = 0, regrst = 0, regtest = 0, regcurar = 0, regdormir = 0;
  logic [2:0] h = 5, d = 5, e = 5, status;
  logic chg, testmode;
  int tests = 0, fails = 0;
  int m_status = 0, m_chg = 0, m_tm = 0, m_run = 0, m_pend = 0, m_starve = 0;
  int seq[7] = '{1, 2, 3, 4, 5, 6, 0};
  int rh = 5, rd = 5, re = 5;

  tama_status_fsm dut (
    .clk(clk), .rst(rst), .tick(tick), .h(h), .d(d), .e(e), .enMue(enMue),
    .regrst(regrst), .regtest(regtest), .regcurar(regcurar), .regdormir(regdormir),
    .status(status), .chg(chg), .testmode(testmode)
  );

  always #5 clk = ~clk;

  function automatic int lv(input int x);
    return x > 5 ? 5 : x;
  endfunction

  // Candidate mood from the needs: 0 FELIZ 1 ABURRIDO 2 CANSADO 4 HAMBRIENTO 5 ENFERMO
  function automatic int need(input int hh, input int dd, input int ee);
    int lows;
    lows = int'(hh <= 1) + int'(dd <= 1) + int'(ee <= 1);
    if (lows >= 2) return 5;
    if (hh <= 1) return 4;
    if (ee <= 1) return 2;
    if (dd <= 1) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_status = 0; m_chg = 0; m_tm = 0; m_run = 0; m_pend = 0; m_starve = 0;
  endtask

  task automatic model_step();
    int prev, hs, ds, es, c;
    prev = m_status;
    hs = lv(int'(h)); ds = lv(int'(d)); es = lv(int'(e));
    c = need(hs, ds, es);
    if (regrst) begin
      m_status = 0; m_tm = 0; m_run = 0; m_starve = 0;
    end else if (regtest) begin
      m_status = (m_status + 1) % 7; m_tm = 1; m_run = 0; m_starve = 0;
    end else if (tick && m_status != 6) begin
      m_starve = (hs == 0) ? (m_starve == 63 ? 63 : m_starve + 1) : 0;
      if (m_status == 5) begin
        if (enMue) m_status = 6;
        else if (regcurar) m_status = 0;
        else if (m_starve >= 60) m_status = 6;
        m_run = 0;
      end else if (m_starve >= 60) m_status = 6;
      else if (m_status == 3) begin
        if (es >= 5 || regdormir) m_status = c;
        m_run = 0;
      end else if (m_status == 2 && regdormir) begin
        m_status = 3; m_run = 0;
      end else if (c == m_status) begin
        m_run = 0; m_pend = c;
      end else begin
        m_run = (c == m_pend) ? m_run + 1 : 1;
        m_pend = c;
        if (m_run == 4) begin
          m_status = c; m_run = 0;
        end
      end
    end
    m_chg = int'(m_status != prev);
  endtask

  task automatic cyc(input bit tk, input int hh, input int dd, input int ee,
                     input bit mue = 0, input bit rr = 0, input bit tt = 0,
                     input bit cc = 0, input bit dm = 0);
    tick = tk; h = 3'(hh); d = 3'(dd); e = 3'(ee);
    enMue = mue; regrst = rr; regtest = tt; regcurar = cc; regdormir = dm;
    model_step();
    @(posedge clk); #1;
    chk("status", status, m_status);
    chk("chg", chg, m_chg);
    chk("testmode", testmode, m_tm);
    tick = 0; enMue = 0; regrst = 0; regtest = 0; regcurar = 0; regdormir = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_status", status, 0);
    chk("rst_chg", chg, 0);
    chk("rst_testmode", testmode, 0);
    rst = 1;
    // short hunger blip must not commit
    repeat (3) cyc(1, 1, 5, 5);
    cyc(1, 3, 5, 5);
    chk("blip_no_commit", status, 0);
    repeat (4) cyc(1, 1, 5, 5);
    chk("hungry_commit", status, 4);
    chk("hungry_chg", chg, 1);
    cyc(0, 1, 5, 5);
    chk("hungry_chg_once", chg, 0);
    // asynchronous reset with a partially built hold
    repeat (2) cyc(1, 5, 5, 5);
    rst = 0;
    #1;
    model_reset();
    chk("midrst_status", status, 0);
    chk("midrst_chg", chg, 0);
    @(posedge clk); #1;
    chk("midrst_chg_next", chg, 0);
    rst = 1;
    repeat (3) cyc(1, 1, 5, 5);
    // sickness, death beats cure, death absorbing
    repeat (4) cyc(1, 1, 5, 0);
    chk("sick_commit", status, 5);
    cyc(1, 1, 5, 0, 1, 0, 0, 1);
    chk("death_wins", status, 6);
    cyc(1, 5, 5, 5, 0, 0, 0, 1);
    chk("dead_absorbing", status, 6);
    cyc(0, 5, 5, 5, 0, 1);
    chk("regrst_revive", status, 0);
    // tired, sleep, wake on full energy
    repeat (4) cyc(1, 5, 5, 1);
    chk("tired_commit", status, 2);
    cyc(1, 5, 5, 1, 0, 0, 0, 0, 1);
    chk("sleep_entry", status, 3);
    repeat (3) cyc(1, 5, 5, 3);
    chk("sleep_stays", status, 3);
    cyc(1, 5, 5, 5);
    chk("wake_no_hold", status, 0);
    // starvation on the 60th tick
    cyc(0, 5, 5, 5, 0, 1);
    for (int i = 1; i <= 60; i++) begin
      cyc(1, 0, 5, 5);
      if (i == 59) chk("starve_59", status, 4);
    end
    chk("starve_60", status, 6);
    cyc(0, 5, 5, 5, 0, 1);
    for (int i = 1; i <= 62; i++) cyc(1, i == 59 ? 2 : 0, 5, 5);
    chk("starve_restart", status, 4);
    // test-mode stepping
    cyc(0, 5, 5, 5, 0, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 5, 5, 5, 0, 0, 1);
      chk("test_step", status, seq[i]);
      chk("test_mode_on", testmode, 1);
    end
    cyc(0, 5, 5, 5, 0, 0, 1);
    cyc(0, 5, 5, 5, 0, 1, 1);
    chk("rst_over_test", status, 0);
    chk("rst_clears_tm", testmode, 0);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rh = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) rd = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) re = $urandom_range(0, 7);
      cyc($urandom_range(0, 2) != 0, rh, rd, re,
          $urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
